// File: rtl/multi_debounce.sv
// N-channel pushbutton conditioner: synchroniser, stability debounce, rise/fall strobes,
// long-press detection and auto-repeat per channel. All outputs are registered.
module multi_debounce #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES   = 100,
  parameter int unsigned REPEAT_CYCLES = 20,
  parameter bit          INVERT        = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] d,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int unsigned StabW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HoldW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int unsigned RepMax = (REPEAT_CYCLES > 1) ? REPEAT_CYCLES - 1 : 0;
  localparam int unsigned RepW   = (RepMax > 0) ? $clog2(RepMax + 1) : 1;

  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(RepMax);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} hold_st_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic             s;
    logic             sync1_q, sync2_q;
    logic             q_q, q_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic             long_q, long_d, rep_q, rep_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    hold_st_e         st_q, st_d;

    assign s = INVERT ? ~d[i] : d[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        q_q       <= 1'b0;
        stab_q    <= '0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        long_q    <= 1'b0;
        rep_q     <= 1'b0;
        hold_q    <= '0;
        rep_cnt_q <= '0;
        st_q      <= StIdle;
      end else begin
        sync1_q   <= s;
        sync2_q   <= sync1_q;
        q_q       <= q_d;
        stab_q    <= stab_d;
        rise_q    <= rise_d;
        fall_q    <= fall_d;
        long_q    <= long_d;
        rep_q     <= rep_d;
        hold_q    <= hold_d;
        rep_cnt_q <= rep_cnt_d;
        st_q      <= st_d;
      end
    end

    // Any agreement between sync2 and q restarts the mismatch count.
    always_comb begin
      q_d    = q_q;
      stab_d = '0;
      if (sync2_q != q_q) begin
        if (stab_q == StabLast) begin
          q_d = sync2_q;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
    end

    always_comb begin
      st_d      = st_q;
      hold_d    = hold_q;
      rep_cnt_d = rep_cnt_q;
      unique case (st_q)
        StIdle: begin
          if (rise_d) begin
            st_d   = StHeld;
            hold_d = '0;
          end
        end
        StHeld: begin
          if (hold_q == HoldLast) begin
            st_d      = StRepeat;
            rep_cnt_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StRepeat: begin
          if (REPEAT_CYCLES != 0) begin
            rep_cnt_d = (rep_cnt_q == RepLast) ? '0 : rep_cnt_q + 1'b1;
          end
        end
        default: st_d = StIdle;
      endcase
      if (fall_d) begin
        st_d      = StIdle;
        hold_d    = '0;
        rep_cnt_d = '0;
      end
    end

    // A release on the same edge suppresses any long/repeat strobe.
    always_comb begin
      long_d = 1'b0;
      rep_d  = 1'b0;
      if (!fall_d) begin
        long_d = (st_q == StHeld) && (hold_q == HoldLast);
        rep_d  = (st_q == StRepeat) && (REPEAT_CYCLES != 0) && (rep_cnt_q == RepLast);
      end
    end

    assign q[i]            = q_q;
    assign rise[i]         = rise_q;
    assign fall[i]         = fall_q;
    assign long_press[i]   = long_q;
    assign repeat_pulse[i] = rep_q;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: an active-high and an active-low instance checked every cycle
// against an event-level model, plus directed timing checks with literal expectations.
module tb_multi_debounce;
  localparam int CH = 2, STABLE = 4, LONG = 10, REP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] d = '0;
  logic [CH-1:0] d_n;
  logic [CH-1:0] q, rise, fall, lp, rp;
  logic [CH-1:0] qi, risei, falli, lpi, rpi;

  assign d_n = ~d;

  multi_debounce #(.CHANNELS(CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG),
                   .REPEAT_CYCLES(REP), .INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .q(q), .rise(rise), .fall(fall),
    .long_press(lp), .repeat_pulse(rp));

  multi_debounce #(.CHANNELS(CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG),
                   .REPEAT_CYCLES(REP), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .d(d_n), .q(qi), .rise(risei), .fall(falli),
    .long_press(lpi), .repeat_pulse(rpi));

  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: level, mismatch run length and edges-since-press per channel.
  bit            m_s1[CH], m_s2[CH], m_q[CH], old2;
  int            m_run[CH], m_t[CH];
  logic [CH-1:0] e_q, e_rise, e_fall, e_lp, e_rp;

  // Event marks taken from the active-high instance (plus inverted rise on ch0).
  int rise_c[CH], fall_c[CH], long_c[CH], rep1_c[CH];
  int n_rise[CH], n_fall[CH], n_long[CH], n_rep[CH], n_qhigh[CH];
  int inv_rise0;

  task automatic clear_marks();
    for (int c = 0; c < CH; c++) begin
      rise_c[c] = -1000; fall_c[c] = -1000; long_c[c] = -1000; rep1_c[c] = -1000;
      n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_qhigh[c] = 0;
    end
    inv_rise0 = -1000;
  endtask

  // d only changes 1 time unit after a negedge, so here it still holds the value
  // the DUT sampled on the preceding posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_q[c] = 0; m_run[c] = 0; m_t[c] = 0;
      end
      e_q = '0; e_rise = '0; e_fall = '0; e_lp = '0; e_rp = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        old2    = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = d[c];
        e_rise[c] = 1'b0; e_fall[c] = 1'b0; e_lp[c] = 1'b0; e_rp[c] = 1'b0;
        if (old2 != m_q[c]) begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_q[c]   = old2;
            m_run[c] = 0;
            if (old2) e_rise[c] = 1'b1;
            else e_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (e_rise[c]) m_t[c] = 0;
        else if (m_q[c] && m_t[c] < 100000) m_t[c]++;
        if (m_q[c] && !e_rise[c]) begin
          e_lp[c] = (m_t[c] == LONG);
          e_rp[c] = (m_t[c] > LONG) && ((m_t[c] - LONG) % REP == 0);
        end
        e_q[c] = m_q[c];
      end
    end
    chk("cycle_outputs_active_high", {q, rise, fall, lp, rp}, {e_q, e_rise, e_fall, e_lp, e_rp});
    chk("cycle_outputs_active_low", {qi, risei, falli, lpi, rpi},
        {e_q, e_rise, e_fall, e_lp, e_rp});
    for (int c = 0; c < CH; c++) begin
      if (q[c]) n_qhigh[c]++;
      if (rise[c]) begin rise_c[c] = cyc; n_rise[c]++; end
      if (fall[c]) begin fall_c[c] = cyc; n_fall[c]++; end
      if (lp[c]) begin long_c[c] = cyc; n_long[c]++; end
      if (rp[c]) begin
        if (n_rep[c] == 0) rep1_c[c] = cyc;
        n_rep[c]++;
      end
    end
    if (risei[0]) inv_rise0 = cyc;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int t0;

  initial begin
    clear_marks();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("reset_state", {q, rise, fall, lp, rp, qi, risei, falli, lpi, rpi}, 0);

    // Async reset while both channels pressed.
    d = 2'b11;
    wait_cyc(8);
    chk("t1_pressed_q", q, 3);
    #2 rst_n = 1'b0;
    #1 chk("t1_async_reset", {q, rise, fall, lp, rp, qi, risei, falli, lpi, rpi}, 0);
    d = 2'b00;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(8);
    chk("t1_idle_after_reset", {q, rise, fall, lp, rp}, 0);

    // Bounce, then a long hold with repeats, then release.
    clear_marks();
    d[0] = 1'b1; wait_cyc(1); d[0] = 1'b0; wait_cyc(2);
    d[0] = 1'b1; wait_cyc(3); d[0] = 1'b0; wait_cyc(1);
    d[0] = 1'b1; wait_cyc(2); d[0] = 1'b0; wait_cyc(1);
    t0 = cyc;
    d[0] = 1'b1;
    wait_cyc(30);
    chk("t2_single_rise", n_rise[0], 1);
    chk("t2_rise_latency", rise_c[0] - t0, 6);
    chk("t2_no_fall", n_fall[0], 0);
    chk("t2_ch1_untouched", n_rise[1], 0);
    chk("t4_long_after_rise", long_c[0] - rise_c[0], 10);
    chk("t4_first_repeat", rep1_c[0] - long_c[0], 3);
    t0 = cyc;
    d[0] = 1'b0;
    wait_cyc(25);
    chk("t4_fall_latency", fall_c[0] - t0, 6);
    chk("t4_repeat_count", n_rep[0], 6);
    chk("t4_long_count", n_long[0], 1);
    chk("t4_fall_count", n_fall[0], 1);

    // Short glitch on channel 1.
    clear_marks();
    d[1] = 1'b1; wait_cyc(3); d[1] = 1'b0;
    wait_cyc(10);
    chk("t3_q1_never_high", n_qhigh[1], 0);
    chk("t3_no_rise1", n_rise[1], 0);
    chk("t3_no_fall1", n_fall[1], 0);

    // Concurrent presses two cycles apart.
    clear_marks();
    t0 = cyc;
    d[0] = 1'b1; wait_cyc(2);
    d[1] = 1'b1; wait_cyc(25);
    chk("t5_rise0_latency", rise_c[0] - t0, 6);
    chk("t5_inv_rise0_latency", inv_rise0 - t0, 6);
    chk("t5_rise_gap", rise_c[1] - rise_c[0], 2);
    chk("t5_long_gap", long_c[1] - long_c[0], 2);
    chk("t5_long0_after_rise", long_c[0] - rise_c[0], 10);
    chk("t5_first_repeat1", rep1_c[1] - long_c[1], 3);
    d = 2'b00;
    wait_cyc(10);
    chk("t5_fall0", n_fall[0], 1);
    chk("t5_fall1", n_fall[1], 1);

    // Reset while auto-repeating, button still held across release.
    clear_marks();
    d[0] = 1'b1;
    wait_cyc(20);
    chk("t6_in_repeat", n_rep[0], 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", {q, rise, fall, lp, rp, qi, risei, falli, lpi, rpi}, 0);
    wait_cyc(2);
    clear_marks();
    t0 = cyc;
    rst_n = 1'b1;
    wait_cyc(20);
    chk("t6_rise_latency", rise_c[0] - t0, 6);
    chk("t6_long_after_rise", long_c[0] - rise_c[0], 10);
    chk("t6_single_rise", n_rise[0], 1);
    d[0] = 1'b0;
    wait_cyc(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
